clk_jitter_gen: RTL and testbench

CLK_JITTER_GEN -- requirements
Module: clk_jitter_gen

---
 rtl/clk_jitter_gen_pkg.sv | 11 +
 rtl/clk_jitter_gen_if.sv | 23 ++
 rtl/clk_jitter_lfsr.sv | 21 ++
 rtl/clk_jitter_gen.sv | 86 ++++++++
 tb/tb_clk_jitter_gen.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_jitter_gen_pkg.sv
// clk_jitter_gen_pkg: shared FSM states, LFSR constants and default widths for clk_jitter_gen
package clk_jitter_gen_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_JIT_W = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/clk_jitter_gen_if.sv
// clk_jitter_gen_if: run/config inputs and generated-clock outputs of clk_jitter_gen
interface clk_jitter_gen_if import clk_jitter_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int JIT_W = DEF_JIT_W
);
  logic             en;
  logic             load;
  logic [CNT_W-1:0] half_period;
  logic [JIT_W-1:0] jitter_max;
  logic             clk_out;
  logic             rise_pulse;
  logic [CNT_W:0]   period_out;
  logic             period_valid;
  logic             busy;
  modport master (
    output en, load, half_period, jitter_max,
    input  clk_out, rise_pulse, period_out, period_valid, busy
  );
  modport slave (
    input  en, load, half_period, jitter_max,
    output clk_out, rise_pulse, period_out, period_valid, busy
  );
endinterface

// File: rtl/clk_jitter_lfsr.sv
// clk_jitter_lfsr: 16-bit Fibonacci LFSR giving a clamped jitter magnitude and sign
module clk_jitter_lfsr import clk_jitter_gen_pkg::*; #(
  parameter int JIT_W = DEF_JIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [JIT_W-1:0] jitter_max,
  output logic [JIT_W-1:0] mag,
  output logic             sign
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = adv ? lfsr_step(lfsr_q) : lfsr_q;
    mag = lfsr_q[JIT_W-1:0] < jitter_max ? lfsr_q[JIT_W-1:0] : jitter_max;
    sign = lfsr_q[15];
  end
  always_ff @(posedge clk) begin
    lfsr_q <= rst ? LFSR_SEED : lfsr_d;
  end
endmodule

// File: rtl/clk_jitter_gen.sv
// clk_jitter_gen: programmable clock generator with optional per-half jitter (macro CLKGEN_JITTER_EN)
module clk_jitter_gen import clk_jitter_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int JIT_W = DEF_JIT_W
) (
  input logic clk,
  input logic rst,
  clk_jitter_gen_if.slave bus
);
  localparam int LW = CNT_W + 1;
  state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d, per_q, per_d, h, len;
  logic [CNT_W-1:0] pend_h_q, pend_h_d, act_h_q, act_h_d;
  logic [JIT_W-1:0] pend_j_q, pend_j_d, act_j_q, act_j_d, mag;
  logic sign, last, to_high, to_low;
  logic clk_out_q, clk_out_d, rise_q, rise_d, pv_q, pv_d;
  // act_*_d is the config a half computed this cycle must use, including a load landing on the rise
  always_comb begin
    last = cnt_q == LW'(1);
    to_high = bus.en && (state_q == IDLE || (state_q == LOW && last));
    to_low = state_q == HIGH && last;
    pend_h_d = bus.load ? bus.half_period : pend_h_q;
    pend_j_d = bus.load ? bus.jitter_max : pend_j_q;
    act_h_d = to_high ? pend_h_d : act_h_q;
    act_j_d = to_high ? pend_j_d : act_j_q;
    h = act_h_d == '0 ? LW'(1) : LW'(act_h_d);
    len = sign ? (h > LW'(mag) ? h - LW'(mag) : LW'(1)) : h + LW'(mag);
    state_d = to_high ? HIGH : to_low ? LOW : (state_q == LOW && last) ? IDLE : state_q;
    cnt_d = (to_high || to_low) ? len : state_q == IDLE ? cnt_q : cnt_q - LW'(1);
    hi_d = to_high ? len : hi_q;
    lo_d = to_low ? len : lo_q;
    clk_out_d = state_d == HIGH;
    rise_d = to_high;
    pv_d = to_high && state_q == LOW;
    per_d = pv_d ? hi_q + lo_q : per_q;
  end
`ifdef CLKGEN_JITTER_EN
  clk_jitter_lfsr #(.JIT_W(JIT_W)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .adv(to_high || to_low),
    .jitter_max(act_j_d),
    .mag(mag),
    .sign(sign)
  );
`else
  logic unused_jit;
  assign mag = '0;
  assign sign = 1'b0;
  assign unused_jit = ^act_j_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      per_q <= '0;
      pend_h_q <= CNT_W'(1);
      act_h_q <= CNT_W'(1);
      pend_j_q <= '0;
      act_j_q <= '0;
      clk_out_q <= 1'b0;
      rise_q <= 1'b0;
      pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      per_q <= per_d;
      pend_h_q <= pend_h_d;
      act_h_q <= act_h_d;
      pend_j_q <= pend_j_d;
      act_j_q <= act_j_d;
      clk_out_q <= clk_out_d;
      rise_q <= rise_d;
      pv_q <= pv_d;
    end
  end
  assign bus.clk_out = clk_out_q;
  assign bus.rise_pulse = rise_q;
  assign bus.period_out = per_q;
  assign bus.period_valid = pv_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_clk_jitter_gen.sv
// tb_clk_jitter_gen: directed and randomized checks of clk_jitter_gen against a half-length scoreboard
module tb_clk_jitter_gen;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  clk_jitter_gen_if bus ();
  clk_jitter_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [15:0] m_lfsr;
  int pend_h, pend_j, act_h, act_j, exp_hi, exp_lo, run_st, run_n, prev_clk;
  int obs_halves[$];
  int obs_per[$];

  // Half length straight from the arithmetic rules: max(1, max(1,H) +/- min(lfsr nibble, jitter_max))
  function automatic int model_len(input int hp, input int jm);
    int hh;
    int mag;
    int v;
    hh = (hp == 0) ? 1 : hp;
    mag = 0;
    v = hh;
`ifdef CLKGEN_JITTER_EN
    mag = (int'(m_lfsr[3:0]) < jm) ? int'(m_lfsr[3:0]) : jm;
    v = m_lfsr[15] ? hh - mag : hh + mag;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    return v < 1 ? 1 : v;
  endfunction

  // Scoreboard: watches clk_out runs after each edge and checks them against model_len
  always begin : scoreboard
    int st;
    logic rise;
    @(posedge clk);
    #1;
    if (rst) begin
      m_lfsr = 16'hACE1;
      pend_h = 1; pend_j = 0; act_h = 1; act_j = 0;
      run_st = 0; run_n = 0; prev_clk = 0;
    end else begin
      if (bus.load) begin
        pend_h = int'(bus.half_period);
        pend_j = int'(bus.jitter_max);
      end
      st = bus.clk_out ? 1 : (bus.busy ? 2 : 0);
      rise = bus.clk_out && prev_clk == 0;
      checks++;
      if (bus.rise_pulse !== rise) begin
        errors++;
        $display("FAIL rise_pulse at %0t: got %b expected %b", $time, bus.rise_pulse, rise);
      end
      checks++;
      if (bus.period_valid !== (rise && run_st == 2)) begin
        errors++;
        $display("FAIL period_valid at %0t: got %b expected %b", $time, bus.period_valid, rise && run_st == 2);
      end
      if (rise && run_st == 2) begin
        checks++;
        if (int'(bus.period_out) != exp_hi + exp_lo) begin
          errors++;
          $display("FAIL period_out at %0t: got %0d expected %0d", $time, bus.period_out, exp_hi + exp_lo);
        end
        obs_per.push_back(int'(bus.period_out));
      end
      if (st != run_st) begin
        if (run_st == 1) begin
          checks++;
          if (run_n != exp_hi) begin
            errors++;
            $display("FAIL high_len at %0t: got %0d expected %0d", $time, run_n, exp_hi);
          end
          obs_halves.push_back(run_n);
        end
        if (run_st == 2) begin
          checks++;
          if (run_n != exp_lo) begin
            errors++;
            $display("FAIL low_len at %0t: got %0d expected %0d", $time, run_n, exp_lo);
          end
          obs_halves.push_back(run_n);
        end
        if (st == 1) begin
          act_h = pend_h;
          act_j = pend_j;
          exp_hi = model_len(act_h, act_j);
        end
        if (st == 2) exp_lo = model_len(act_h, act_j);
        run_st = st;
        run_n = 1;
      end else begin
        run_n++;
      end
      prev_clk = int'(bus.clk_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_cfg(input int hp, input int jm);
    bus.half_period = 16'(hp);
    bus.jitter_max = 4'(jm);
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    for (int i = 0; i < 100 && bus.rise_pulse !== 1'b1; i++) tick(1);
    ok = bus.rise_pulse === 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 300 && bus.busy !== 1'b0; i++) tick(1);
    ok = bus.busy === 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.load = 1'b1;
    bus.half_period = 16'd7;
    bus.jitter_max = 4'd5;
    tick(3);
    checks++;
    if ({bus.clk_out, bus.rise_pulse, bus.period_valid, bus.busy, bus.period_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got clk_out=%b rise=%b pv=%b busy=%b period=%0d expected all 0",
               bus.clk_out, bus.rise_pulse, bus.period_valid, bus.busy, bus.period_out);
    end
    rst = 1'b0;
    bus.load = 1'b0;
    bus.jitter_max = 4'd0;
    tick(1);
    checks++;
    if (bus.clk_out !== 1'b1 || bus.rise_pulse !== 1'b1) begin
      errors++;
      $display("FAIL first_rise: got clk_out=%b rise=%b expected 1 1", bus.clk_out, bus.rise_pulse);
    end
    tick(1);
    checks++;
    if (bus.clk_out !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL default_half: got clk_out=%b busy=%b expected 0 1", bus.clk_out, bus.busy);
    end
    bus.en = 1'b0;
    tick(1);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_fixed_period(input int hp, input int exp_half, input int run_cycles);
    bit ok;
    load_cfg(hp, 0);
    obs_halves.delete();
    obs_per.delete();
    bus.en = 1'b1;
    wait_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fixed_rise_timeout: got no rise expected rise"); end
    tick(run_cycles);
    bus.en = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fixed_idle_timeout: got busy expected idle"); end
    checks++;
    if (obs_halves.size() < 6 || obs_per.size() != obs_halves.size() / 2 - 1) begin
      errors++;
      $display("FAIL fixed_counts: got %0d halves %0d periods expected >=6 halves and halves/2-1 periods",
               obs_halves.size(), obs_per.size());
    end
    foreach (obs_halves[i]) begin
      checks++;
      if (obs_halves[i] != exp_half) begin
        errors++;
        $display("FAIL fixed_half[%0d]: got %0d expected %0d", i, obs_halves[i], exp_half);
      end
    end
    foreach (obs_per[i]) begin
      checks++;
      if (obs_per[i] != 2 * exp_half) begin
        errors++;
        $display("FAIL fixed_period[%0d]: got %0d expected %0d", i, obs_per[i], 2 * exp_half);
      end
    end
  endtask

  task automatic test_load_mid_high;
    bit ok;
    int exp_h[4] = '{4, 4, 8, 8};
    load_cfg(4, 0);
    obs_halves.delete();
    obs_per.delete();
    bus.en = 1'b1;
    wait_rise(ok);
    tick(1);
    bus.half_period = 16'd8;
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
    wait_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midload_rise_timeout: got no rise expected rise"); end
    bus.en = 1'b0;
    wait_idle(ok);
    checks++;
    if (obs_halves.size() != 4 || obs_per.size() != 1) begin
      errors++;
      $display("FAIL midload_counts: got %0d halves %0d periods expected 4 1", obs_halves.size(), obs_per.size());
    end else begin
      foreach (exp_h[i]) begin
        checks++;
        if (obs_halves[i] != exp_h[i]) begin
          errors++;
          $display("FAIL midload_half[%0d]: got %0d expected %0d", i, obs_halves[i], exp_h[i]);
        end
      end
      checks++;
      if (obs_per[0] != 8) begin
        errors++;
        $display("FAIL midload_period: got %0d expected 8", obs_per[0]);
      end
    end
  endtask

  task automatic test_load_at_transition;
    bit ok;
    int exp_h[4] = '{3, 3, 2, 2};
    load_cfg(5, 0);
    obs_halves.delete();
    obs_per.delete();
    bus.half_period = 16'd3;
    bus.load = 1'b1;
    bus.en = 1'b1;
    tick(1);
    bus.load = 1'b0;
    tick(5);
    bus.half_period = 16'd2;
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
    tick(1);
    bus.en = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || obs_halves.size() != 4) begin
      errors++;
      $display("FAIL edge_load_counts: got %0d halves expected 4", obs_halves.size());
    end else begin
      foreach (exp_h[i]) begin
        checks++;
        if (obs_halves[i] != exp_h[i]) begin
          errors++;
          $display("FAIL edge_load_half[%0d]: got %0d expected %0d", i, obs_halves[i], exp_h[i]);
        end
      end
    end
  endtask

  task automatic test_en_drop;
    bit ok;
    load_cfg(4, 0);
    obs_halves.delete();
    bus.en = 1'b1;
    wait_rise(ok);
    tick(1);
    bus.en = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || obs_halves.size() != 2 || obs_halves[0] != 4 || obs_halves[1] != 4) begin
      errors++;
      $display("FAIL en_drop_halves: got %0d halves expected 2 halves of 4", obs_halves.size());
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (bus.clk_out !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL en_drop_idle: got clk_out=%b busy=%b expected 0 0", bus.clk_out, bus.busy);
      end
    end
  endtask

  task automatic test_jitter;
    bit ok;
    int npv = 0;
    int seen[int];
`ifdef CLKGEN_JITTER_EN
    int hmin = 2, hmax = 8, pmin = 4, pmax = 16, dmin = 3;
`else
    int hmin = 5, hmax = 5, pmin = 10, pmax = 10, dmin = 1;
`endif
    load_cfg(5, 3);
    obs_halves.delete();
    obs_per.delete();
    bus.en = 1'b1;
    for (int i = 0; i < 6000 && npv < 200; i++) begin
      tick(1);
      if (bus.period_valid === 1'b1) npv++;
    end
    bus.en = 1'b0;
    wait_idle(ok);
    checks++;
    if (npv != 200 || !ok) begin
      errors++;
      $display("FAIL jitter_run: got %0d periods expected 200", npv);
    end
    foreach (obs_halves[i]) begin
      checks++;
      if (obs_halves[i] < hmin || obs_halves[i] > hmax) begin
        errors++;
        $display("FAIL jitter_half[%0d]: got %0d expected [%0d,%0d]", i, obs_halves[i], hmin, hmax);
      end
    end
    foreach (obs_per[i]) begin
      seen[obs_per[i]] = 1;
      checks++;
      if (obs_per[i] < pmin || obs_per[i] > pmax) begin
        errors++;
        $display("FAIL jitter_period[%0d]: got %0d expected [%0d,%0d]", i, obs_per[i], pmin, pmax);
      end
    end
    checks++;
    if (seen.num() < dmin) begin
      errors++;
      $display("FAIL jitter_distinct: got %0d distinct periods expected >= %0d", seen.num(), dmin);
    end
  endtask

  task automatic test_rst_mid_low;
    bit ok;
`ifdef CLKGEN_JITTER_EN
    int exp_first = 5;
`else
    int exp_first = 6;
`endif
    load_cfg(6, 3);
    bus.en = 1'b1;
    wait_rise(ok);
    for (int i = 0; i < 100 && bus.clk_out !== 1'b0; i++) tick(1);
    tick(1);
    checks++;
    if (bus.clk_out !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: got clk_out=%b busy=%b expected 0 1", bus.clk_out, bus.busy);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({bus.clk_out, bus.rise_pulse, bus.period_valid, bus.busy, bus.period_out} !== '0) begin
      errors++;
      $display("FAIL rst_mid_low: got clk_out=%b rise=%b pv=%b busy=%b period=%0d expected all 0",
               bus.clk_out, bus.rise_pulse, bus.period_valid, bus.busy, bus.period_out);
    end
    rst = 1'b0;
    bus.en = 1'b0;
    tick(2);
    load_cfg(6, 3);
    obs_halves.delete();
    bus.en = 1'b1;
    tick(1);
    checks++;
    if (bus.rise_pulse !== 1'b1 || bus.clk_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_reenable_rise: got rise=%b clk_out=%b expected 1 1", bus.rise_pulse, bus.clk_out);
    end
    bus.en = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || obs_halves.size() != 2 || obs_halves[0] != exp_first) begin
      errors++;
      $display("FAIL rst_lfsr_restart: got %0d halves first=%0d expected 2 halves first=%0d",
               obs_halves.size(), obs_halves.size() > 0 ? obs_halves[0] : -1, exp_first);
    end
  endtask

  task automatic test_random;
    bit ok;
    int n;
    for (int r = 0; r < 12; r++) begin
      load_cfg($urandom_range(0, 9), $urandom_range(0, 15));
      bus.en = 1'b1;
      n = $urandom_range(10, 60);
      for (int c = 0; c < n; c++) begin
        bus.load = ($urandom_range(0, 7) == 0);
        bus.half_period = 16'($urandom_range(0, 9));
        bus.jitter_max = 4'($urandom_range(0, 15));
        tick(1);
      end
      bus.load = 1'b0;
      bus.en = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_idle[%0d]: got busy=%b expected 0", r, bus.busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.half_period = '0;
    bus.jitter_max = '0;
    test_reset();
    test_fixed_period(5, 5, 30);
    test_fixed_period(0, 1, 6);
    test_load_mid_high();
    test_load_at_transition();
    test_en_drop();
    test_jitter();
    test_rst_mid_low();
    test_random();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
